apb_slave_mem: RTL



---
 rtl/apb_slave_mem.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/apb_slave_mem.sv
// APB slave memory with byte strobes, programmable wait states, error responses
// and saturating per-type transfer statistics.
module apb_slave_mem #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int DEPTH      = 16,
   parameter int WAIT_W     = 4,
   parameter int PROT_CHECK = 0,
   parameter int CNT_W      = 16
) (
   input  logic                apb_clk_i,
   input  logic                apb_reset_i,
   input  logic [ADDR_W-1:0]   apb_addr_i,
   input  logic                apb_sel_i,
   input  logic                apb_enable_i,
   input  logic                apb_write_i,
   input  logic [DATA_W/8-1:0] apb_strb_i,
   input  logic [2:0]          apb_prot_i,
   input  logic [DATA_W-1:0]   apb_wdata_i,
   output logic                apb_ready_o,
   output logic [DATA_W-1:0]   apb_rdata_o,
   output logic                apb_slverr_o,
   input  logic [WAIT_W-1:0]   cfg_wait_i,
   output logic [CNT_W-1:0]    wr_count_o,
   output logic [CNT_W-1:0]    rd_count_o,
   output logic [CNT_W-1:0]    err_count_o
);

   localparam int STRB_W = DATA_W / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int IDX_W  = $clog2(DEPTH);

   typedef enum logic {
      IDLE,
      ACCESS
   } state_t;

   state_t              state, state_nxt;
   logic                start, done, ready;
   logic [IDX_W-1:0]    setup_idx, idx_q;
   logic                setup_err, err_q, write_q;
   logic [STRB_W-1:0]   strb_q;
   logic [DATA_W-1:0]   wdata_q, rdata_q;
   logic [WAIT_W-1:0]   wait_q;
   logic [CNT_W-1:0]    wr_cnt, rd_cnt, err_cnt;
   logic [DATA_W-1:0]   mem [DEPTH];

   // Any set bit above the index field addresses a word beyond DEPTH.
   assign setup_idx = apb_addr_i[OFF_W +: IDX_W];
   assign setup_err = (|apb_addr_i[ADDR_W-1:OFF_W+IDX_W])
                    | ((PROT_CHECK != 0) & apb_write_i & ~apb_prot_i[0]);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge apb_clk_i) begin
      if (apb_reset_i) state <= IDLE;
      else             state <= state_nxt;
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      done      = 1'b0;
      ready     = 1'b0;
      case (state)
         IDLE: begin
            if (apb_sel_i) begin
               start     = 1'b1;
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            if (!apb_sel_i) begin
               state_nxt = IDLE;
            end else if (wait_q == '0) begin
               ready = 1'b1;
               if (apb_enable_i) begin
                  done      = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign apb_ready_o  = ready;
   assign apb_slverr_o = ready & err_q;
   assign apb_rdata_o  = rdata_q;

   always_ff @(posedge apb_clk_i) begin
      if (apb_reset_i) begin
         idx_q   <= '0;
         write_q <= 1'b0;
         strb_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         wait_q  <= '0;
         rdata_q <= '0;
      end else if (start) begin
         idx_q   <= setup_idx;
         write_q <= apb_write_i;
         strb_q  <= apb_strb_i;
         wdata_q <= apb_wdata_i;
         err_q   <= setup_err;
         wait_q  <= cfg_wait_i;
         if (!apb_write_i) rdata_q <= setup_err ? '0 : mem[setup_idx];
      end else if (state == ACCESS && apb_sel_i && wait_q != '0) begin
         wait_q <= wait_q - WAIT_W'(1);
      end
   end

   // NOTE: the storage is flop-based and cleared by reset, so it cannot map onto a RAM macro.
   always_ff @(posedge apb_clk_i) begin
      if (apb_reset_i) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (done && write_q && !err_q) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (strb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

   always_ff @(posedge apb_clk_i) begin
      if (apb_reset_i) begin
         wr_cnt  <= '0;
         rd_cnt  <= '0;
         err_cnt <= '0;
      end else if (done) begin
         if (err_q)        err_cnt <= sat_inc(err_cnt);
         else if (write_q) wr_cnt  <= sat_inc(wr_cnt);
         else              rd_cnt  <= sat_inc(rd_cnt);
      end
   end

   assign wr_count_o  = wr_cnt;
   assign rd_count_o  = rd_cnt;
   assign err_count_o = err_cnt;

endmodule
